cska_wide_seq: RTL and testbench

CSKA_WIDE_SEQ -- requirements
Module: cska_wide_seq

---
 rtl/cska_pkg.sv | 26 ++
 rtl/cska_slice.sv | 52 +++++
 rtl/cska_wide_seq.sv | 130 +++++++++++++
 tb/tb_cska_wide_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cska_pkg.sv
// ============================================================================
// cska_pkg : shared FSM encoding and beat-count helpers for cska_wide_seq
// Revision : 1.0
// ============================================================================
`default_nettype none

package cska_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int C_BLK       = 4;
    localparam int C_DEF_WIDTH = 64;
    localparam int C_DEF_SLICE = 16;
    localparam int C_DEF_N     = C_DEF_WIDTH / C_DEF_SLICE;

    function automatic int num_beats(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cska_slice.sv
// ============================================================================
// cska_slice : SLICE-bit carry-skip adder assembled from 4-bit ripple blocks
// Revision   : 1.0
// ============================================================================
`default_nettype none

module cska_slice
    import cska_pkg::*;
#(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    localparam int C_NB = SLICE / C_BLK;

    logic [C_NB:0] w_c;

    assign w_c[0] = cin_i;

    genvar g;
    generate
        for (g = 0; g < C_NB; g++) begin : g_blk
            logic [C_BLK-1:0] w_p;
            logic [C_BLK-1:0] w_g;
            logic [C_BLK:0]   w_rc;

            assign w_p = a_i[g*C_BLK +: C_BLK] ^ b_i[g*C_BLK +: C_BLK];
            assign w_g = a_i[g*C_BLK +: C_BLK] & b_i[g*C_BLK +: C_BLK];

            always_comb begin
                w_rc[0] = w_c[g];
                for (int i = 0; i < C_BLK; i++) begin
                    w_rc[i+1] = w_g[i] | (w_p[i] & w_rc[i]);
                end
            end

            assign sum_o[g*C_BLK +: C_BLK] = w_p ^ w_rc[C_BLK-1:0];
            // A fully propagating block forwards its carry-in straight past the ripple chain.
            assign w_c[g+1] = (&w_p) ? w_c[g] : w_rc[C_BLK];
        end
    endgenerate

    assign cout_o = w_c[C_NB];

endmodule

`default_nettype wire

// File: rtl/cska_wide_seq.sv
// ============================================================================
// cska_wide_seq : WIDTH-bit add/subtract, computed one SLICE per cycle
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cska_wide_seq
    import cska_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int SLICE = C_DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C_N  = num_beats(WIDTH, SLICE);
    localparam int C_KW = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_KW-1:0] C_LAST = C_KW'(C_N - 1);

    generate
        if ((WIDTH % SLICE) != 0 || (SLICE % C_BLK) != 0) begin : g_bad_params
            $error("cska_wide_seq: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [C_KW-1:0]  k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    cska_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (a_q[k_q*SLICE +: SLICE]),
        .b_i    (b_q[k_q*SLICE +: SLICE]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so B is stored already inverted.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[k_q*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                k_d     = k_q + 1'b1;
                if (k_q == C_LAST) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[SLICE-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cska_wide_seq.sv
// ============================================================================
// tb_cska_wide_seq : directed and randomised checks of cska_wide_seq
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_cska_wide_seq;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cska_wide_seq #(
        .WIDTH (64),
        .SLICE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns #1 after the accepting edge.
    task automatic do_accept(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic tc, input logic ts);
        int n;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edge count includes the accepting edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_clr"}, 64'(out_valid), 64'd0);
        chk({tag, "_iready_set"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        int lat;
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    initial begin
        logic [W-1:0] ra, rb, eb, es, held;
        logic         rc, rs, ec, eo;
        logic [W:0]   full;
        int           lat, hold;
        logic         saw_valid;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check_result("wrap", 64'd0, 1'b1, 1'b0);
        consume("wrap");

        do_accept(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check_result("posovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        consume("posovf");

        do_accept(64'd5, 64'd7, 1'b0, 1'b1);
        check_result("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        consume("sub_neg");

        // cin must be ignored for subtraction
        do_accept(64'd10, 64'd3, 1'b1, 1'b1);
        check_result("sub_cin", 64'd7, 1'b1, 1'b0);
        consume("sub_cin");

        do_accept(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        check_result("negovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        consume("negovf");

        do_accept(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0);
        check_result("cin_slice", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        consume("cin_slice");

        // Operands and in_valid toggle during RUN and must not disturb the result.
        do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        in_valid = 1'b1; a = 64'h1234; b = 64'h5678; sub = 1'b1; cin = 1'b0;
        check_result("cin_skip", 64'd0, 1'b1, 1'b0);
        consume("cin_skip");

        do_accept(64'd3, 64'd4, 1'b0, 1'b0);
        check_result("hold", 64'd7, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", sum, 64'd7);
        end
        consume("hold");

        do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_sum", sum, 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_valid = saw_valid | out_valid;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 64'(saw_valid), 64'd0);
        do_accept(64'd100, 64'd23, 1'b1, 1'b0);
        check_result("post_abort", 64'd124, 1'b0, 1'b0);
        consume("post_abort");

        for (int t = 0; t < 24; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (t == 0) begin ra = 64'h8000_0000_0000_0000; rb = 64'h8000_0000_0000_0000; rs = 1'b0; end
            eb   = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, eb} + {64'd0, (rs ? 1'b1 : rc)};
            es   = full[W-1:0];
            ec   = full[W];
            eo   = (ra[W-1] == eb[W-1]) && (es[W-1] != ra[W-1]);
            do_accept(ra, rb, rc, rs);
            lat = 1;
            while (!out_valid && lat < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                lat++;
            end
            chk("rnd_latency", 64'(lat), 64'd5);
            chk("rnd_sum", sum, es);
            chk("rnd_cout", 64'(cout), 64'(ec));
            chk("rnd_ovf", 64'(ovf), 64'(eo));
            held = sum;
            if (!out_ready) begin
                hold = $urandom_range(0, 2);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    chk("rnd_hold_sum", sum, held);
                end
            end
            consume("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
